// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//   WIDTH-bit storage/serialiser element. Each edge (priority rst > en > mode)
//   does one of: hold, parallel load, shift left/right with serial fill,
//   rotate left/right, or clear. A shift counter tracks shift/rotate
//   operations since the last load/clear/reset and pulses word_done on the
//   edge that applies the WIDTH-th one.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (q <= RST_VAL)
//   en         clock enable; 0 holds all state
//   mode[2:0]  000 HOLD, 001 LOAD, 010 SHL, 011 SHR,
//              100 ROTL, 101 ROTR, 110 CLEAR, 111 HOLD
//   d          parallel load data
//   sin_l      serial in at MSB end (SHR)
//   sin_r      serial in at LSB end (SHL)
//   q          register contents
//   sout_l     q[WIDTH-1]
//   sout_r     q[0]
//   shift_cnt  shift/rotate count, 0..WIDTH-1
//   word_done  one-cycle pulse after the WIDTH-th shift
// -----------------------------------------------------------------------------

package usr_pkg;
  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROTL  = 3'b100,
    M_ROTR  = 3'b101,
    M_CLEAR = 3'b110,
    M_RSVD  = 3'b111
  } mode_e;

  // Per-bit control shared by every cell. take_lo pulls from the bit below
  // (left shift/rotate), take_hi from the bit above (right shift/rotate).
  typedef struct packed {
    logic ld;
    logic clr;
    logic take_lo;
    logic take_hi;
  } bit_ctl_t;
endpackage

// -----------------------------------------------------------------------------
// usr_bit_cell: one storage bit with its next-state select.
//   clk/rst     clock and synchronous reset
//   rst_val_i   this bit's reset value
//   en_i        clock enable
//   ctl_i       decoded operation
//   d_i         parallel load bit
//   lo_i/hi_i   neighbour (or serial/wrap) bits below/above
//   q_o         stored bit
// -----------------------------------------------------------------------------
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     rst_val_i,
  input  logic     en_i,
  input  bit_ctl_t ctl_i,
  input  logic     d_i,
  input  logic     lo_i,
  input  logic     hi_i,
  output logic     q_o
);
  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      if (ctl_i.ld)           q_d = d_i;
      else if (ctl_i.clr)     q_d = 1'b0;
      else if (ctl_i.take_lo) q_d = lo_i;
      else if (ctl_i.take_hi) q_d = hi_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= rst_val_i;
    else     q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// -----------------------------------------------------------------------------
// universal_shift_reg top
// -----------------------------------------------------------------------------
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2:0]               mode,
  input  logic [WIDTH-1:0]         d,
  input  logic                     sin_l,
  input  logic                     sin_r,
  output logic [WIDTH-1:0]         q,
  output logic                     sout_l,
  output logic                     sout_r,
  output logic [$clog2(WIDTH):0]   shift_cnt,
  output logic                     word_done
);
  localparam int CW = $clog2(WIDTH) + 1;

  mode_e            mode_s;
  bit_ctl_t         ctl;
  logic             is_shift;
  logic [WIDTH-1:0] lo_in, hi_in;

  assign mode_s = mode_e'(mode);

  always_comb begin
    ctl      = '0;
    is_shift = 1'b0;
    case (mode_s)
      M_LOAD:         ctl.ld  = 1'b1;
      M_CLEAR:        ctl.clr = 1'b1;
      M_SHL, M_ROTL: begin
        ctl.take_lo = 1'b1;
        is_shift    = 1'b1;
      end
      M_SHR, M_ROTR: begin
        ctl.take_hi = 1'b1;
        is_shift    = 1'b1;
      end
      default: ;  // HOLD and reserved
    endcase
  end

  // End bits take either the serial input or the opposite end (rotate).
  assign lo_in = {q[WIDTH-2:0], (mode_s == M_ROTL) ? q[WIDTH-1] : sin_r};
  assign hi_in = {(mode_s == M_ROTR) ? q[0] : sin_l, q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .rst_val_i (RST_VAL[i]),
      .en_i      (en),
      .ctl_i     (ctl),
      .d_i       (d[i]),
      .lo_i      (lo_in[i]),
      .hi_i      (hi_in[i]),
      .q_o       (q[i])
    );
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  // Shift counter: wraps WIDTH-1 -> 0 and flags the completed word.
  // LOAD/CLEAR take precedence over a pending wrap.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      if (ctl.ld || ctl.clr) begin
        cnt_d = '0;
      end else if (is_shift) begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign shift_cnt = cnt_q;
  assign word_done = done_q;
endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register. It is the successor to the team's single-bit D flip-flop: a WIDTH-bit register with clock enable, synchronous reset, parallel load, logical shift in both directions, rotate and clear. A shift counter flags each completed full-word serial transfer. It serves as the general storage/serialiser element for the serial-link and datapath blocks that follow.

## Interface
- WIDTH, default 8: register width in bits; legal range is 2 or more.
- RST_VAL, default 0: value loaded into q on reset (WIDTH bits).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  3  operation select (see Operation).
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial in at the MSB end (used by shift right).
- sin_r  input  1  serial in at the LSB end (used by shift left).
- q  output  WIDTH  register contents.
- sout_l  output  1  equals q[WIDTH-1] (combinational from q).
- sout_r  output  1  equals q[0] (combinational from q).
- shift_cnt  output  $clog2(WIDTH)+1  shift/rotate operations since the last load, clear, reset or wrap.
- word_done  output  1  one-cycle pulse marking the completion of the WIDTH-th shift.

## Operation
- Priority at each rising edge of clk: rst, then en, then mode.
- rst=1: q=RST_VAL, shift_cnt=0, word_done=0. This applies regardless of en or mode.
- en=0: q and shift_cnt hold; word_done=0.
- en=1, mode decode:
  - 000 HOLD: q holds; shift_cnt holds.
  - 001 LOAD: q=d; shift_cnt=0.
  - 010 SHL: q={q[WIDTH-2:0], sin_r}.
  - 011 SHR: q={sin_l, q[WIDTH-1:1]}.
  - 100 ROTL: q={q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROTR: q={q[0], q[WIDTH-1:1]}.
  - 110 CLEAR: q=0 (not RST_VAL); shift_cnt=0.
  - 111 reserved: behaves exactly as HOLD.
- Counter rules for SHL, SHR, ROTL and ROTR:
  - If shift_cnt==WIDTH-1: shift_cnt wraps to 0 and word_done=1 for one cycle.
  - Otherwise shift_cnt increments by 1.
- word_done is 0 in every cycle not covered by the wrap rule.
- Mixing shift directions or rotate modes does not reset the counter; each counts as one operation.
- LOAD or CLEAR in the cycle a wrap would otherwise occur: LOAD/CLEAR wins, shift_cnt=0, word_done=0.
- The block has no internal FSM beyond the counter. The counter occupies states 0..WIDTH-1; the value WIDTH is never visible on shift_cnt.

## Timing
- All state (q, shift_cnt, word_done) is registered and updates on the rising edge of clk only.
- Latency is 1 cycle: inputs sampled at edge N appear on q/shift_cnt after edge N.
- word_done is registered and asserts after the same edge that applies the WIDTH-th shift. It lasts exactly one cycle unless the next wrap falls in the following cycle, which is possible only when WIDTH==1 and is therefore illegal.
- sout_l/sout_r follow q with zero added latency. They carry no combinational path from inputs.
- Reset mid-transfer: at the reset edge, q=RST_VAL, shift_cnt=0 and word_done=0. A wrap that would have occurred on that edge is suppressed.
- No X propagation from unused inputs: d is ignored except in LOAD, sin_l except in SHR, and sin_r except in SHL.

## Test plan
- Reset: WIDTH=8, RST_VAL=8'h3C; hold rst=1 for 2 edges with en=1 and mode=LOAD, d=8'hFF -> q=8'h3C, shift_cnt=0, word_done=0.
- Serial out: LOAD 8'hA5, then 8× SHL with sin_r=0 -> sout_l sequence 1,0,1,0,0,1,0,1 (sampled before each shift). Final q=8'h00, shift_cnt returns to 0, and word_done is high only in the cycle after the 8th shift.
- Rotate and mix: LOAD 8'h81 then ROTR -> 8'hC0; then ROTL -> 8'h81; then SHR with sin_l=1 -> 8'hC0; shift_cnt=3.
- Enable and reserved mode: LOAD 8'h5A; en=0 with mode=SHL for 3 cycles -> q stays 8'h5A, shift_cnt stays 0. Then en=1, mode=111 for 2 cycles -> unchanged.
- Counter override: 7× SHL, then LOAD 8'h0F on the 8th cycle -> q=8'h0F, shift_cnt=0, and word_done never asserts. 3× SHL then CLEAR -> q=8'h00, shift_cnt=0.
- Reset mid-transfer: LOAD 8'hFF, 5× SHR, then rst=1 for 1 edge -> q=RST_VAL, shift_cnt=0. Next 8 shifts yield word_done exactly once, after the 8th.
